// File: rtl/stp_sr_rx_fifo_pkg.sv
// Shared definitions for the serial receive shifter and its word buffer.
package stp_sr_rx_fifo_pkg;

    // Order in which serial bits are assembled into a received word.
    typedef enum logic {
        LSB_FIRST = 1'b0,
        MSB_FIRST = 1'b1
    } bit_order_e;

    // Default word width and buffer depth used by the receiver.
    localparam int DEFAULT_DATA_W     = 8;
    localparam int DEFAULT_FIFO_DEPTH = 4;

endpackage

// File: rtl/rx_word_fifo.sv
// Synchronous word FIFO with occupancy count, head-of-queue output that reads
// zero while empty, and a drop strobe for pushes that find no free entry.
module rx_word_fifo #(
    parameter int DATA_W = stp_sr_rx_fifo_pkg::DEFAULT_DATA_W,
    parameter int DEPTH  = stp_sr_rx_fifo_pkg::DEFAULT_FIFO_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        push_data_i,
    input  logic                     pop_req_i,
    output logic [DATA_W-1:0]        head_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     drop_o
);
    import stp_sr_rx_fifo_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty, full, pop, wr;

    // Occupancy decode, push/pop qualification and next pointer/count values.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_W'(DEPTH));
        pop      = !empty && pop_req_i;
        // A full FIFO still takes a word when the head leaves in the same cycle.
        wr       = push_i && (!full || pop);
        drop_o   = push_i && full && !pop;
        wr_ptr_d = wr  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        unique case ({wr, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count state; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful below the count, so no reset.
    always_ff @(posedge clk_i) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Head word is forced to zero while nothing is buffered.
    always_comb begin
        valid_o = !empty;
        head_o  = empty ? '0 : mem_q[rd_ptr_q];
        count_o = count_q;
    end

endmodule

// File: rtl/stp_sr_rx_fifo.sv
// Serial-to-parallel receiver: shifts SDA_sync on qualified SCL rising edges,
// pushes each completed word into a small FIFO, and flags dropped words.
module stp_sr_rx_fifo #(
    parameter int DATA_W     = stp_sr_rx_fifo_pkg::DEFAULT_DATA_W,
    parameter int MSB_FIRST  = 1,
    parameter int FIFO_DEPTH = stp_sr_rx_fifo_pkg::DEFAULT_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          SDA_sync,
    input  logic                          rising_edge,
    input  logic                          rx_enable,
    input  logic                          frame_clr,
    output logic [DATA_W-1:0]             rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          word_done,
    output logic [$clog2(DATA_W)-1:0]     bit_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          overflow_clr
);
    import stp_sr_rx_fifo_pkg::*;

    localparam int CNT_W = $clog2(DATA_W);
    localparam bit_order_e ORDER = (MSB_FIRST != 0) ? stp_sr_rx_fifo_pkg::MSB_FIRST
                                                    : stp_sr_rx_fifo_pkg::LSB_FIRST;

    logic [DATA_W-1:0] shreg_q, shreg_d, shifted;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              word_done_q, overflow_q, overflow_d;
    logic              shift_en, last_bit, word_push, fifo_drop;

    // Shift/count next state; frame_clr overrides any coincident sample.
    always_comb begin
        shift_en  = rx_enable && rising_edge;
        last_bit  = (bit_cnt_q == CNT_W'(DATA_W - 1));
        if (ORDER == stp_sr_rx_fifo_pkg::MSB_FIRST) begin
            shifted = {shreg_q[DATA_W-2:0], SDA_sync};
        end else begin
            shifted = {SDA_sync, shreg_q[DATA_W-1:1]};
        end
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        word_push = 1'b0;
        if (frame_clr) begin
            shreg_d   = '0;
            bit_cnt_d = '0;
        end else if (shift_en) begin
            shreg_d = shifted;
            if (last_bit) begin
                // The completing bit goes straight into the pushed word.
                bit_cnt_d = '0;
                word_push = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end
    end

    // Sticky overflow: a new drop wins over a clear in the same cycle.
    always_comb begin
        if (fifo_drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Receiver state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            word_done_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            word_done_q <= word_push;
            overflow_q  <= overflow_d;
        end
    end

    rx_word_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (word_push),
        .push_data_i (shifted),
        .pop_req_i   (rx_ready),
        .head_o      (rx_data),
        .valid_o     (rx_valid),
        .count_o     (fifo_count),
        .drop_o      (fifo_drop)
    );

    // Status outputs.
    always_comb begin
        bit_cnt   = bit_cnt_q;
        word_done = word_done_q;
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_stp_sr_rx_fifo.sv
// Directed bench for stp_sr_rx_fifo: default MSB-first receiver with a word
// scoreboard, plus LSB-first and 12-bit instances on the same shared inputs.
module tb_stp_sr_rx_fifo;

    logic clk = 1'b0;
    logic rst, sda, rise, fclr, rdy, oclr;
    logic en_m, en_l, en_w;

    logic [7:0]  rd_m;  logic rv_m, wd_m, of_m;  logic [2:0] bc_m; logic [2:0] fc_m;
    logic [7:0]  rd_l;  logic rv_l, wd_l, of_l;  logic [2:0] bc_l; logic [2:0] fc_l;
    logic [11:0] rd_w;  logic rv_w, wd_w, of_w;  logic [3:0] bc_w; logic [2:0] fc_w;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    stp_sr_rx_fifo #(.DATA_W(8), .MSB_FIRST(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .SDA_sync(sda), .rising_edge(rise), .rx_enable(en_m),
        .frame_clr(fclr), .rx_data(rd_m), .rx_valid(rv_m), .rx_ready(rdy),
        .word_done(wd_m), .bit_cnt(bc_m), .fifo_count(fc_m), .overflow(of_m),
        .overflow_clr(oclr)
    );

    stp_sr_rx_fifo #(.DATA_W(8), .MSB_FIRST(0), .FIFO_DEPTH(4)) dut_lsb (
        .clk(clk), .rst(rst), .SDA_sync(sda), .rising_edge(rise), .rx_enable(en_l),
        .frame_clr(fclr), .rx_data(rd_l), .rx_valid(rv_l), .rx_ready(rdy),
        .word_done(wd_l), .bit_cnt(bc_l), .fifo_count(fc_l), .overflow(of_l),
        .overflow_clr(oclr)
    );

    stp_sr_rx_fifo #(.DATA_W(12), .MSB_FIRST(1), .FIFO_DEPTH(4)) dut_w12 (
        .clk(clk), .rst(rst), .SDA_sync(sda), .rising_edge(rise), .rx_enable(en_w),
        .frame_clr(fclr), .rx_data(rd_w), .rx_valid(rv_w), .rx_ready(rdy),
        .word_done(wd_w), .bit_cnt(bc_w), .fifo_count(fc_w), .overflow(of_w),
        .overflow_clr(oclr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sda  = b;
        rise = 1'b1;
        tick();
        rise = 1'b0;
        sda  = 1'b0;
    endtask

    task automatic send_msb(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    // Pops the main instance until the scoreboard is empty, within a cycle budget.
    task automatic drain(input string tag);
        logic [7:0] exp;
        rdy = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (sb_q.size() == 0) break;
            if (rv_m === 1'b1) begin
                exp = sb_q.pop_front();
                chk(tag, {24'h0, rd_m}, {24'h0, exp});
            end
            tick();
        end
        rdy = 1'b0;
        chk({tag, "_left"}, sb_q.size(), 0);
        chk({tag, "_empty"}, {31'h0, rv_m}, 32'h0);
        chk({tag, "_zero"}, {24'h0, rd_m}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sda = 1'b0; rise = 1'b0; fclr = 1'b0; rdy = 1'b0; oclr = 1'b0;
        en_m = 1'b0; en_l = 1'b0; en_w = 1'b0;
        tick(); tick();
        chk("rst_data", {24'h0, rd_m}, 32'h0);
        chk("rst_valid", {31'h0, rv_m}, 32'h0);
        chk("rst_count", {29'h0, fc_m}, 32'h0);
        chk("rst_bitcnt", {29'h0, bc_m}, 32'h0);
        chk("rst_wdone", {31'h0, wd_m}, 32'h0);
        chk("rst_ovf", {31'h0, of_m}, 32'h0);
        rst = 1'b0;
        tick();

        // A5 on both bit orders (symmetric pattern), word_done single pulse.
        en_m = 1'b1; en_l = 1'b1;
        send_msb(32'hA5 >> 1, 7);
        chk("a5_bitcnt7", {29'h0, bc_m}, 32'd7);
        chk("a5_nodone", {31'h0, wd_m}, 32'h0);
        send_bit(1'b1);
        sb_q.push_back(8'hA5);
        chk("a5_done", {31'h0, wd_m}, 32'h1);
        chk("a5_valid", {31'h0, rv_m}, 32'h1);
        chk("a5_data", {24'h0, rd_m}, 32'hA5);
        chk("a5_count", {29'h0, fc_m}, 32'h1);
        chk("a5_bitwrap", {29'h0, bc_m}, 32'h0);
        chk("a5_lsb_data", {24'h0, rd_l}, 32'hA5);
        tick();
        chk("a5_done_once", {31'h0, wd_m}, 32'h0);
        chk("a5_count_hold", {29'h0, fc_m}, 32'h1);
        drain("a5_drain");

        // Asymmetric stream: first bit lands in MSB vs LSB.
        send_msb(32'h80, 8);
        sb_q.push_back(8'h80);
        chk("ord_lsb_data", {24'h0, rd_l}, 32'h01);
        drain("ord_drain");
        chk("ord_lsb_empty", {31'h0, rv_l}, 32'h0);

        // 12-bit word of all ones.
        en_m = 1'b0; en_l = 1'b0; en_w = 1'b1;
        send_msb(32'hFFF, 12);
        chk("w12_data", {20'h0, rd_w}, 32'hFFF);
        chk("w12_done", {31'h0, wd_w}, 32'h1);
        chk("w12_bitwrap", {28'h0, bc_w}, 32'h0);
        rdy = 1'b1; tick(); rdy = 1'b0;
        chk("w12_empty", {31'h0, rv_w}, 32'h0);

        // Overflow: fifth word into a full FIFO is dropped.
        en_w = 1'b0; en_m = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            send_msb(v, 8);
            sb_q.push_back(v[7:0]);
        end
        chk("ovf_full_count", {29'h0, fc_m}, 32'd4);
        chk("ovf_not_yet", {31'h0, of_m}, 32'h0);
        send_msb(32'h05, 8);
        chk("ovf_set", {31'h0, of_m}, 32'h1);
        chk("ovf_count", {29'h0, fc_m}, 32'd4);
        drain("ovf_drain");
        chk("ovf_sticky", {31'h0, of_m}, 32'h1);

        // Refill; a drop coinciding with overflow_clr keeps the flag set.
        for (int v = 8'h11; v <= 8'h14; v++) begin
            send_msb(v, 8);
            sb_q.push_back(v[7:0]);
        end
        send_msb(32'h15 >> 1, 7);
        oclr = 1'b1;
        send_bit(1'b1);
        oclr = 1'b0;
        chk("ovf_setwins", {31'h0, of_m}, 32'h1);
        oclr = 1'b1; tick(); oclr = 1'b0;
        chk("ovf_cleared", {31'h0, of_m}, 32'h0);

        // Push and pop together while full: count holds, no overflow.
        send_msb(32'h16 >> 1, 7);
        rdy = 1'b1;
        chk("pp_head", {24'h0, rd_m}, {24'h0, sb_q.pop_front()});
        send_bit(1'b0);
        rdy = 1'b0;
        sb_q.push_back(8'h16);
        chk("pp_count", {29'h0, fc_m}, 32'd4);
        chk("pp_noovf", {31'h0, of_m}, 32'h0);
        chk("pp_done", {31'h0, wd_m}, 32'h1);
        drain("pp_drain");

        // frame_clr after 3 bits, then a clean 3C.
        send_msb(32'h7, 3);
        chk("fc_partial", {29'h0, bc_m}, 32'd3);
        fclr = 1'b1; tick(); fclr = 1'b0;
        chk("fc_bitcnt", {29'h0, bc_m}, 32'h0);
        send_msb(32'h3C, 8);
        sb_q.push_back(8'h3C);
        chk("fc_data", {24'h0, rd_m}, 32'h3C);
        // frame_clr coincident with a shift discards the sample.
        send_msb(32'h3, 2);
        fclr = 1'b1;
        send_bit(1'b1);
        fclr = 1'b0;
        chk("fc_coinc_bitcnt", {29'h0, bc_m}, 32'h0);
        chk("fc_coinc_count", {29'h0, fc_m}, 32'h1);
        drain("fc_drain");

        // Reset mid-word with two words buffered.
        send_msb(32'h5A, 8);
        send_msb(32'hC3, 8);
        send_msb(32'h16, 5);
        chk("mr_pre_count", {29'h0, fc_m}, 32'd2);
        chk("mr_pre_bitcnt", {29'h0, bc_m}, 32'd5);
        rst = 1'b1;
        #1;
        chk("mr_data", {24'h0, rd_m}, 32'h0);
        chk("mr_valid", {31'h0, rv_m}, 32'h0);
        chk("mr_count", {29'h0, fc_m}, 32'h0);
        chk("mr_bitcnt", {29'h0, bc_m}, 32'h0);
        chk("mr_wdone", {31'h0, wd_m}, 32'h0);
        chk("mr_ovf", {31'h0, of_m}, 32'h0);
        sb_q.delete();
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("mr_post_wdone", {31'h0, wd_m}, 32'h0);
        chk("mr_post_valid", {31'h0, rv_m}, 32'h0);
        send_msb(32'h81, 8);
        sb_q.push_back(8'h81);
        chk("mr_81_data", {24'h0, rd_m}, 32'h81);
        chk("mr_81_count", {29'h0, fc_m}, 32'h1);
        drain("mr_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
